// File: rtl/keccak_cmd_sequencer.sv
// Expands one SHAKE request into core/in-adapter/out-adapter commands; KECCAK_CMD_SEQUENCER_STATS_EN adds done_count/done_pulse.
// Latency: one command per cycle, 4..6 cycles from request accept back to IDLE.
// Backpressure: each command holds stable until consumed; stalls in place, no request accepted until IDLE.
module keccak_cmd_sequencer #(
    parameter int BlockCntW = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BlockCntW+18:0] req,
    input  logic                 req_isReady,
    output logic                 req_canReceive,
    output logic [BlockCntW+4:0] k__cmd,
    output logic                 k__cmd_isReady,
    input  logic                 k__cmd_canReceive,
    output logic [10:0]          k_in__cmd,
    output logic                 k_in__cmd_isReady,
    input  logic                 k_in__cmd_canReceive,
    output logic [1:0]           k_out__cmd,
    output logic                 k_out__cmd_isReady,
    input  logic                 k_out__cmd_canReceive,
    output logic                 busy
`ifdef KECCAK_CMD_SEQUENCER_STATS_EN
    ,
    output logic [15:0]          done_count,
    output logic                 done_pulse
`endif
);

    typedef struct packed {
        logic                 is128;
        logic                 sample;
        logic                 has_prefix;
        logic [7:0]           prefix;
        logic [7:0]           zero_cnt;
        logic [BlockCntW-1:0] out_blocks;
    } req_t;

    typedef enum logic [2:0] {
        IDLE,
        KCMD,
        IN_PREFIX,
        IN_FWD,
        IN_ZEROS,
        OUT
    } state_t;

    localparam logic [1:0] IN_SEND_BYTE  = 2'b00;
    localparam logic [1:0] IN_SEND_ZEROS = 2'b01;
    localparam logic [1:0] IN_FORWARD    = 2'b10;

    state_t state_q, state_d;
    req_t   req_q, req_d;
    logic   has_zeros;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    assign has_zeros = (req_q.zero_cnt != 8'h00);
    assign busy      = (state_q != IDLE);

    // Data buses are zero whenever their isReady is low, so every output defaults to zero here.
    always_comb begin
        state_d            = state_q;
        req_d              = req_q;
        req_canReceive     = 1'b0;
        k__cmd             = '0;
        k__cmd_isReady     = 1'b0;
        k_in__cmd          = '0;
        k_in__cmd_isReady  = 1'b0;
        k_out__cmd         = '0;
        k_out__cmd_isReady = 1'b0;
        case (state_q)
            IDLE: begin
                req_canReceive = 1'b1;
                if (req_isReady) begin
                    req_d   = req;
                    state_d = KCMD;
                end
            end
            KCMD: begin
                k__cmd_isReady = 1'b1;
                k__cmd         = {req_q.is128, 3'b000, req_q.out_blocks, 1'b1};
                if (k__cmd_canReceive)
                    state_d = req_q.has_prefix ? IN_PREFIX : IN_FWD;
            end
            IN_PREFIX: begin
                k_in__cmd_isReady = 1'b1;
                k_in__cmd         = {req_q.prefix, 1'b1, IN_SEND_BYTE};
                if (k_in__cmd_canReceive)
                    state_d = IN_FWD;
            end
            IN_FWD: begin
                // The forwarded stream is the last input unless zero padding follows it.
                k_in__cmd_isReady = 1'b1;
                k_in__cmd         = {8'h00, has_zeros, IN_FORWARD};
                if (k_in__cmd_canReceive)
                    state_d = has_zeros ? IN_ZEROS : OUT;
            end
            IN_ZEROS: begin
                k_in__cmd_isReady = 1'b1;
                k_in__cmd         = {req_q.zero_cnt, 1'b0, IN_SEND_ZEROS};
                if (k_in__cmd_canReceive)
                    state_d = OUT;
            end
            OUT: begin
                k_out__cmd_isReady = 1'b1;
                k_out__cmd         = {1'b0, req_q.sample};
                if (k_out__cmd_canReceive)
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef KECCAK_CMD_SEQUENCER_STATS_EN
    logic [15:0] done_count_q, done_count_d;

    assign done_pulse = (state_q == OUT) && k_out__cmd_canReceive;
    assign done_count = done_count_q;

    always_comb begin
        done_count_d = done_count_q;
        if (done_pulse)
            done_count_d = done_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            done_count_q <= '0;
        else
            done_count_q <= done_count_d;
    end
`endif

endmodule

// File: tb/tb_keccak_cmd_sequencer.sv
// Directed bench for keccak_cmd_sequencer: per-cycle expected bus activity and data.
module tb_keccak_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [27:0] req;
    logic        req_isReady;
    logic        req_canReceive;
    logic [13:0] k__cmd;
    logic        k__cmd_isReady;
    logic        k__cmd_canReceive;
    logic [10:0] k_in__cmd;
    logic        k_in__cmd_isReady;
    logic        k_in__cmd_canReceive;
    logic [1:0]  k_out__cmd;
    logic        k_out__cmd_isReady;
    logic        k_out__cmd_canReceive;
    logic        busy;
`ifdef KECCAK_CMD_SEQUENCER_STATS_EN
    logic [15:0] done_count;
    logic        done_pulse;
    int          pulse_cnt = 0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    keccak_cmd_sequencer #(.BlockCntW(9)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .req                   (req),
        .req_isReady           (req_isReady),
        .req_canReceive        (req_canReceive),
        .k__cmd                (k__cmd),
        .k__cmd_isReady        (k__cmd_isReady),
        .k__cmd_canReceive     (k__cmd_canReceive),
        .k_in__cmd             (k_in__cmd),
        .k_in__cmd_isReady     (k_in__cmd_isReady),
        .k_in__cmd_canReceive  (k_in__cmd_canReceive),
        .k_out__cmd            (k_out__cmd),
        .k_out__cmd_isReady    (k_out__cmd_isReady),
        .k_out__cmd_canReceive (k_out__cmd_canReceive),
        .busy                  (busy)
`ifdef KECCAK_CMD_SEQUENCER_STATS_EN
        ,
        .done_count            (done_count),
        .done_pulse            (done_pulse)
`endif
    );

`ifdef KECCAK_CMD_SEQUENCER_STATS_EN
    always @(negedge clk) begin
        if (done_pulse === 1'b1)
            pulse_cnt++;
    end
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [27:0] mk_req(input logic is128, input logic sample, input logic hp,
                                           input logic [7:0] prefix, input logic [7:0] zeros,
                                           input logic [8:0] outb);
        return {is128, sample, hp, prefix, zeros, outb};
    endfunction

    // er: expected {k_out, k_in, k_cmd} isReady; ed: expected data on the active bus.
    task automatic check_bus(input string tag, input logic [2:0] er, input logic [13:0] ed);
        check_eq({tag, "_rdy"}, {k_out__cmd_isReady, k_in__cmd_isReady, k__cmd_isReady}, er);
        check_eq({tag, "_kcmd"}, k__cmd, er[0] ? ed : 14'h0);
        check_eq({tag, "_kin"}, k_in__cmd, er[1] ? ed[10:0] : 11'h0);
        check_eq({tag, "_kout"}, k_out__cmd, er[2] ? ed[1:0] : 2'h0);
        check_eq({tag, "_busy"}, busy, er != 3'b000);
        check_eq({tag, "_reqrdy"}, req_canReceive, er == 3'b000);
    endtask

    task automatic send_req(input logic [27:0] r);
        req         = r;
        req_isReady = 1'b1;
        tick();
        req_isReady = 1'b0;
    endtask

    localparam logic [2:0] R_IDLE = 3'b000;
    localparam logic [2:0] R_KCMD = 3'b001;
    localparam logic [2:0] R_KIN  = 3'b010;
    localparam logic [2:0] R_KOUT = 3'b100;

    initial begin
        rst                   = 1'b1;
        req                   = '0;
        req_isReady           = 1'b0;
        k__cmd_canReceive     = 1'b1;
        k_in__cmd_canReceive  = 1'b1;
        k_out__cmd_canReceive = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check_bus("reset", R_IDLE, 14'h0);
        tick();

        // Full request, all consumers ready: 6 cycles back to IDLE.
        send_req(mk_req(1'b1, 1'b1, 1'b1, 8'h96, 8'h04, 9'd5));
        check_bus("t1_kcmd", R_KCMD, 14'b1000_000000101_1);
        tick(); check_bus("t1_prefix", R_KIN, {3'b000, 8'h96, 1'b1, 2'b00});
        tick(); check_bus("t1_fwd", R_KIN, {3'b000, 8'h00, 1'b1, 2'b10});
        tick(); check_bus("t1_zeros", R_KIN, {3'b000, 8'h04, 1'b0, 2'b01});
        tick(); check_bus("t1_out", R_KOUT, 14'b01);
        tick(); check_bus("t1_idle", R_IDLE, 14'h0);

        // No prefix, no zeros, max outBlocks: 4 cycles.
        send_req(mk_req(1'b0, 1'b0, 1'b0, 8'hAA, 8'h00, 9'h1FF));
        check_bus("t2_kcmd", R_KCMD, {1'b0, 3'b000, 9'h1FF, 1'b1});
        tick(); check_bus("t2_fwd", R_KIN, {3'b000, 8'h00, 1'b0, 2'b10});
        tick(); check_bus("t2_out", R_KOUT, 14'b00);
        tick(); check_bus("t2_idle", R_IDLE, 14'h0);

        // outBlocks = 0 passes through.
        send_req(mk_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 9'd0));
        check_bus("t2b_kcmd", R_KCMD, 14'b1000_000000000_1);
        tick(); tick(); tick();
        check_bus("t2b_idle", R_IDLE, 14'h0);

        // Back-pressure in IN_FWD for 10 cycles.
        k_in__cmd_canReceive = 1'b0;
        send_req(mk_req(1'b0, 1'b1, 1'b0, 8'h00, 8'h03, 9'd2));
        check_bus("t3_kcmd", R_KCMD, {1'b0, 3'b000, 9'd2, 1'b1});
        tick();
        for (int i = 0; i < 10; i++) begin
            check_bus($sformatf("t3_stall%0d", i), R_KIN, {3'b000, 8'h00, 1'b1, 2'b10});
            tick();
        end
        k_in__cmd_canReceive = 1'b1;
        check_bus("t3_fwd", R_KIN, {3'b000, 8'h00, 1'b1, 2'b10});
        tick(); check_bus("t3_zeros", R_KIN, {3'b000, 8'h03, 1'b0, 2'b01});
        tick(); check_bus("t3_out", R_KOUT, 14'b01);
        tick(); check_bus("t3_idle", R_IDLE, 14'h0);

        // Back-to-back: req stays valid; B accepted in the cycle IDLE is re-entered.
        req         = mk_req(1'b1, 1'b0, 1'b1, 8'h5A, 8'h00, 9'd1);
        req_isReady = 1'b1;
        tick();
        req = mk_req(1'b0, 1'b1, 1'b0, 8'h00, 8'h02, 9'd3);
        check_bus("t4a_kcmd", R_KCMD, 14'b1000_000000001_1);
        tick(); check_bus("t4a_prefix", R_KIN, {3'b000, 8'h5A, 1'b1, 2'b00});
        tick(); check_bus("t4a_fwd", R_KIN, {3'b000, 8'h00, 1'b0, 2'b10});
        tick(); check_bus("t4a_out", R_KOUT, 14'b00);
        tick(); check_bus("t4_idle", R_IDLE, 14'h0);
        tick();
        req_isReady = 1'b0;
        check_bus("t4b_kcmd", R_KCMD, 14'b0000_000000011_1);
        tick(); check_bus("t4b_fwd", R_KIN, {3'b000, 8'h00, 1'b1, 2'b10});
        tick(); check_bus("t4b_zeros", R_KIN, {3'b000, 8'h02, 1'b0, 2'b01});
        tick(); check_bus("t4b_out", R_KOUT, 14'b01);
        tick(); check_bus("t4b_idle", R_IDLE, 14'h0);

        // Reset while in IN_PREFIX, then a fresh request restarts from KCMD.
        send_req(mk_req(1'b1, 1'b1, 1'b1, 8'h11, 8'h05, 9'd4));
        check_bus("t5_kcmd", R_KCMD, 14'b1000_000000100_1);
        tick(); check_bus("t5_prefix", R_KIN, {3'b000, 8'h11, 1'b1, 2'b00});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_bus("t5_rst", R_IDLE, 14'h0);
        send_req(mk_req(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 9'd7));
        check_bus("t5_kcmd2", R_KCMD, 14'b0000_000000111_1);
        tick(); check_bus("t5_fwd", R_KIN, {3'b000, 8'h00, 1'b0, 2'b10});
        tick(); check_bus("t5_out", R_KOUT, 14'b01);
        tick(); check_bus("t5_idle", R_IDLE, 14'h0);

`ifdef KECCAK_CMD_SEQUENCER_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pulse_cnt = 0;
        check_eq("st_reset", done_count, 16'd0);
        for (int i = 0; i < 3; i++) begin
            send_req(mk_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 9'd1));
            tick(); tick(); tick();
        end
        check_eq("st_count3", done_count, 16'd3);
        check_eq("st_pulse3", pulse_cnt, 32'd3);
        force dut.done_count_q = 16'hFFFF;
        tick();
        release dut.done_count_q;
        tick();
        check_eq("st_preload", done_count, 16'hFFFF);
        send_req(mk_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 9'd1));
        tick(); tick();
        check_eq("st_pulse_hi", done_pulse, 1'b1);
        tick();
        check_eq("st_pulse_lo", done_pulse, 1'b0);
        check_eq("st_wrap", done_count, 16'd0);
        check_eq("st_pulse4", pulse_cnt, 32'd4);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
